// File: rtl/cl_pkg.sv
// -----------------------------------------------------------------------------
// cl_pkg
// Shared definitions for the cl bitwise logic unit.
//
// Contents:
//   CL_OP_W  - width of the operation select field
//   OP_AND   - s = 2'b00 : a AND b
//   OP_OR    - s = 2'b01 : a OR  b
//   OP_XOR   - s = 2'b10 : a XOR b
//   OP_NOTA  - s = 2'b11 : NOT a (b ignored)
//   cl_op_e  - enumerated view of the same encodings, for readable debug
//
// Optional build macro used by the importing RTL: CL_PARITY_EN
// -----------------------------------------------------------------------------
package cl_pkg;

    localparam int CL_OP_W = 2;

    localparam logic [CL_OP_W-1:0] OP_AND  = 2'b00;
    localparam logic [CL_OP_W-1:0] OP_OR   = 2'b01;
    localparam logic [CL_OP_W-1:0] OP_XOR  = 2'b10;
    localparam logic [CL_OP_W-1:0] OP_NOTA = 2'b11;

    typedef enum logic [CL_OP_W-1:0] {
        CL_AND  = OP_AND,
        CL_OR   = OP_OR,
        CL_XOR  = OP_XOR,
        CL_NOTA = OP_NOTA
    } cl_op_e;

endpackage : cl_pkg

// File: rtl/cl_alu.sv
// -----------------------------------------------------------------------------
// cl_alu
// Purely combinational bitwise function unit. No clock, no reset.
//
// Parameters:
//   WIDTH  - operand/result width in bits (>= 1)
//
// Ports:
//   out    output [WIDTH-1:0]  result of the selected bitwise operation
//   a      input  [WIDTH-1:0]  operand A
//   b      input  [WIDTH-1:0]  operand B (ignored for NOT a)
//   s      input  [1:0]        operation select (encodings in cl_pkg)
// -----------------------------------------------------------------------------
module cl_alu
    import cl_pkg::*;
#(
    parameter int WIDTH = 1
)
(
    output logic [WIDTH-1:0]   out,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [CL_OP_W-1:0] s
);

    always_comb begin
        out = '0;
        case (s)
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            OP_XOR:  out = a ^ b;
            OP_NOTA: out = ~a;
            // Only reachable when s carries X/Z; propagate the unknown
            // instead of silently picking an operation.
            default: out = 'x;
        endcase
    end

endmodule : cl_alu

// File: rtl/cl.sv
// -----------------------------------------------------------------------------
// cl
// Bitwise logic unit with a combinational result and a one-deep registered
// copy qualified by a valid flag.
//
// Parameters:
//   WIDTH      - operand/result width in bits (>= 1)
//
// Ports (the first four keep positional order out, a, b, s):
//   out        output [WIDTH-1:0]  combinational result, independent of clk/rst
//   a          input  [WIDTH-1:0]  operand A
//   b          input  [WIDTH-1:0]  operand B
//   s          input  [1:0]        operation select (AND/OR/XOR/NOT a)
//   clk        input               rising-edge clock for the registered path
//   rst        input               asynchronous, active-high reset
//   in_valid   input               capture out into out_q on the next edge
//   out_q      output [WIDTH-1:0]  registered copy of out (holds when idle)
//   out_valid  output              out_q was captured on the previous edge
//   parity_q   output              XOR-reduction of out_q
//                                  (present only when CL_PARITY_EN is defined)
//
// Build macro: CL_PARITY_EN adds parity_q and its register.
// -----------------------------------------------------------------------------
module cl
    import cl_pkg::*;
#(
    parameter int WIDTH = 1
)
(
    output logic [WIDTH-1:0]   out,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [CL_OP_W-1:0] s,
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   out_q,
    output logic               out_valid
`ifdef CL_PARITY_EN
    ,
    output logic               parity_q
`endif
);

    logic [WIDTH-1:0] out_p1;
    logic             vld_p1;

    cl_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .out (out),
        .a   (a),
        .b   (b),
        .s   (s)
    );

    // ---- stage p1: capture the combinational result ----
    // The data register is reset as well so out_q reads 0 while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            out_p1 <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                out_p1 <= out;
            end
        end
    end

    assign out_q     = out_p1;
    assign out_valid = vld_p1;

`ifdef CL_PARITY_EN
    logic par_p1;

    // Parity is registered alongside out_p1 from the same source, so it
    // always describes the value currently held in out_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_p1 <= 1'b0;
        end else if (in_valid) begin
            par_p1 <= ^out;
        end
    end

    assign parity_q = par_p1;
`endif

endmodule : cl

// File: tb/tb_cl.sv
// -----------------------------------------------------------------------------
// tb_cl
// Self-checking bench for cl: WIDTH=1 and WIDTH=4 instances, combinational
// truth-table sweep, registered path via a scoreboard, and reset behaviour.
// Build macro honoured: CL_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_cl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [0:0] a1, b1, out1, q1;
    logic [1:0] s1;
    logic       iv1, v1;

    logic [3:0] a4, b4, out4, q4;
    logic [1:0] s4;
    logic       iv4, v4;

`ifdef CL_PARITY_EN
    logic       p1, p4;
`endif

    int checks   = 0;
    int failures = 0;

    logic [0:0] sb[$];
    logic [0:0] exp_q1 = 1'b0;
    bit         mon_en = 1'b0;

    logic [3:0] exp4 [4];

    always #5 clk = ~clk;

    cl #(.WIDTH(1)) dut1 (
        .out       (out1),
        .a         (a1),
        .b         (b1),
        .s         (s1),
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv1),
        .out_q     (q1),
`ifdef CL_PARITY_EN
        .parity_q  (p1),
`endif
        .out_valid (v1)
    );

    cl #(.WIDTH(4)) dut4 (
        .out       (out4),
        .a         (a4),
        .b         (b4),
        .s         (s4),
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv4),
        .out_q     (q4),
`ifdef CL_PARITY_EN
        .parity_q  (p4),
`endif
        .out_valid (v4)
    );

    function automatic logic [3:0] model(input logic [1:0] op,
                                         input logic [3:0] x,
                                         input logic [3:0] y);
        case (op)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~x;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the WIDTH=1 registered path: push at each capturing
    // edge, pop when the DUT reports out_valid.
    always @(posedge clk) begin : mon
        logic       cap;
        logic [3:0] m;
        if (mon_en && !rst) begin
            cap = iv1;
            if (cap) begin
                m = model(s1, {3'b000, a1}, {3'b000, b1});
                sb.push_back(m[0]);
            end
            #1;
            check("mon_vld", {31'd0, v1}, {31'd0, cap});
            if (cap) begin
                if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
                else exp_q1 = sb.pop_front();
            end
            check("mon_q", {31'd0, q1}, {31'd0, exp_q1});
`ifdef CL_PARITY_EN
            check("mon_par", {31'd0, p1}, {31'd0, ^exp_q1});
`endif
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        logic [3:0] m;
        exp4[0] = 4'b1000;
        exp4[1] = 4'b1110;
        exp4[2] = 4'b0110;
        exp4[3] = 4'b0011;
        a1 = '0; b1 = '0; s1 = '0; iv1 = 1'b0;
        a4 = '0; b4 = '0; s4 = '0; iv4 = 1'b0;

        // Reset asserted between edges must clear immediately.
        #1 rst = 1'b1;
        #1;
        check("rst_q1",   {31'd0, q1}, 32'd0);
        check("rst_vld1", {31'd0, v1}, 32'd0);
        check("rst_q4",   {28'd0, q4}, 32'd0);
        check("rst_vld4", {31'd0, v4}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Full truth-table sweep at WIDTH=1, each pattern held 20 ns.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            s1  = k[3:2];
            a1  = k[1];
            b1  = k[0];
            iv1 = 1'b1;
            #3;
            m = model(s1, {3'b000, a1}, {3'b000, b1});
            check("alu_w1", {31'd0, out1}, {31'd0, m[0]});
            @(negedge clk);
        end

        // NOT a ignores b.
        @(negedge clk);
        s1 = 2'b11; a1 = 1'b0; b1 = 1'b1;
        #3 check("nota_a0_b1", {31'd0, out1}, 32'd1);
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0;
        #3 check("nota_a1_b0", {31'd0, out1}, 32'd0);

        // Capture, then idle edge: valid drops, data holds.
        @(negedge clk);
        s1 = 2'b01; a1 = 1'b1; b1 = 1'b0; iv1 = 1'b1;
        @(posedge clk);
        #2;
        check("cap_q",   {31'd0, q1}, 32'd1);
        check("cap_vld", {31'd0, v1}, 32'd1);
        @(negedge clk);
        iv1 = 1'b0;
        @(posedge clk);
        #2;
        check("idle_vld", {31'd0, v1}, 32'd0);
        check("idle_q",   {31'd0, q1}, 32'd1);

        // WIDTH=4 operations, combinational and registered.
        @(negedge clk);
        a4 = 4'b1100; b4 = 4'b1010; iv4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s4 = k[1:0];
            #3 check("alu_w4", {28'd0, out4}, {28'd0, exp4[k]});
            @(posedge clk);
            #1;
            check("q_w4",   {28'd0, q4}, {28'd0, exp4[k]});
            check("vld_w4", {31'd0, v4}, 32'd1);
            @(negedge clk);
        end

        // out = 0111 has odd parity.
        a4 = 4'b0101; b4 = 4'b0011; s4 = 2'b01;
        #3 check("alu_0111", {28'd0, out4}, 32'h7);
        @(posedge clk);
        #1;
        check("q_0111", {28'd0, q4}, 32'h7);
`ifdef CL_PARITY_EN
        check("par_0111", {31'd0, p4}, 32'd1);
`endif

        // Mid-operation reset while out_valid is high.
        @(negedge clk);
        mon_en = 1'b0;
        s1 = 2'b01; a1 = 1'b1; b1 = 1'b0; iv1 = 1'b1;
        @(posedge clk);
        #2;
        check("pre_rst_vld", {31'd0, v1}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_q",   {31'd0, q1},   32'd0);
        check("mid_rst_vld", {31'd0, v1},   32'd0);
        check("mid_rst_out", {31'd0, out1}, 32'd1);
        check("mid_rst_q4",  {28'd0, q4},   32'd0);
`ifdef CL_PARITY_EN
        check("mid_rst_par4", {31'd0, p4}, 32'd0);
`endif
        // A clock edge during reset with in_valid high must not capture.
        @(posedge clk);
        #1;
        check("rst_edge_vld", {31'd0, v1}, 32'd0);
        check("rst_edge_q",   {31'd0, q1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_q1 = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #2;
        check("post_rst_q",   {31'd0, q1}, 32'd1);
        check("post_rst_vld", {31'd0, v1}, 32'd1);

        @(negedge clk);
        mon_en = 1'b0;
        iv1 = 1'b0;
        iv4 = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cl
